// File: rtl/redmule_pkg.sv
// ---------------------------------------------------------------------------
// redmule_pkg
// Shared types and constants for the reduction sink.
//   red_sink_state_e : sink controller states
//   RED_SINK_DEPTH   : default number of row-block slots kept between passes
//   red_sink_addr_w  : slot address width for a given depth (minimum 1 bit)
// ---------------------------------------------------------------------------
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH    = 4;
    localparam int unsigned RED_SINK_DEPTH = 8;
    localparam int unsigned RED_SINK_CNT_W = 16;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_INIT    = 2'd1,
        RS_COLLECT = 2'd2,
        RS_FINISH  = 2'd3
    } red_sink_state_e;

    function automatic int unsigned red_sink_addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/redmule_red_slot_mem.sv
// ---------------------------------------------------------------------------
// redmule_red_slot_mem
// Flip-flop register file holding one partial reduction vector per row-block
// slot. One synchronous write port, one asynchronous read port, no reset
// (contents are always written in pass 0 before being read in later passes).
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write slot
//   wdata_i  : write vector
//   raddr_i  : read slot
//   rdata_o  : read vector (combinational)
// ---------------------------------------------------------------------------
module redmule_red_slot_mem #(
    parameter int unsigned Depth = 8,
    parameter int unsigned DataW = 64,
    parameter int unsigned AddrW = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/redmule_reduction_sink.sv
// ---------------------------------------------------------------------------
// redmule_reduction_sink
// Closes the loop around the row-wise reduction unit. In non-final passes the
// finished vectors are parked in a slot buffer and replayed as init vectors
// for the same row block in the next pass; in the final pass they are sent
// to the output streamer through a registered valid/ready port.
//
// Ports:
//   clk_i, rst_i, clear_i          : clock, sync active-high reset, soft clear
//   start_i, num_slots_i,
//   num_passes_i                   : job start and configuration
//   red_enable_o, red_load_o,
//   red_ready_o                    : reduction-unit control
//   init_o, init_valid_o,
//   red_is_init_i                  : init vector handshake
//   red_i, red_valid_i             : reduction result
//   out_o, out_valid_o, out_ready_i: final vector stream
//   busy_o, done_o                 : job status
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RS_IDLE    | waiting for start_i
// RS_INIT    | reduction unit initialising (neutral or replayed slot vector)
// RS_COLLECT | waiting for the result of the current slot
// RS_FINISH  | draining the last output beat, then pulsing done_o
// ---------------------------------------------------------------------------
module redmule_reduction_sink
    import redmule_pkg::*;
#(
    parameter int unsigned Width = ARRAY_WIDTH,
    parameter int unsigned BITW  = 16,
    parameter int unsigned Depth = RED_SINK_DEPTH,
    parameter int unsigned CntW  = RED_SINK_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CntW-1:0]       num_slots_i,
    input  logic [CntW-1:0]       num_passes_i,
    output logic                  red_enable_o,
    output logic                  red_load_o,
    output logic [Width*BITW-1:0] init_o,
    output logic                  init_valid_o,
    input  logic                  red_is_init_i,
    input  logic [Width*BITW-1:0] red_i,
    input  logic                  red_valid_i,
    output logic                  red_ready_o,
    output logic [Width*BITW-1:0] out_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned DataW = Width * BITW;
    localparam int unsigned AddrW = red_sink_addr_w(Depth);

    red_sink_state_e  state_q, state_d;
    logic [CntW-1:0]  pass_q, pass_d;
    logic [CntW-1:0]  slot_q, slot_d;
    logic [CntW-1:0]  slots_q, slots_d;
    logic [CntW-1:0]  passes_q, passes_d;
    logic [DataW-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic             mem_we;
    logic [DataW-1:0] mem_rdata;
    logic [AddrW-1:0] slot_addr;
    logic             last_slot;
    logic             final_pass;
    logic             cfg_bad;
    logic             red_hs;

    assign slot_addr  = slot_q[AddrW-1:0];
    assign last_slot  = (slot_q == slots_q - CntW'(1));
    assign final_pass = (pass_q == passes_q - CntW'(1));
    assign cfg_bad    = (num_slots_i == '0) || (num_passes_i == '0)
                     || (num_slots_i > CntW'(Depth));
    assign red_hs     = red_valid_i & red_ready_o;

    redmule_red_slot_mem #(
        .Depth (Depth),
        .DataW (DataW),
        .AddrW (AddrW)
    ) i_slot_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we & ~(rst_i | clear_i)),
        .waddr_i (slot_addr),
        .wdata_i (red_i),
        .raddr_i (slot_addr),
        .rdata_o (mem_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= RS_IDLE;
            pass_q      <= '0;
            slot_q      <= '0;
            slots_q     <= '0;
            passes_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            slot_q      <= slot_d;
            slots_q     <= slots_d;
            passes_q    <= passes_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counters and output register loading
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        slot_d      = slot_q;
        slots_d     = slots_q;
        passes_d    = passes_q;
        out_d       = out_q;
        out_valid_d = out_valid_q & ~out_ready_i;
        done_d      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            RS_IDLE: begin
                if (start_i) begin
                    slots_d  = num_slots_i;
                    passes_d = num_passes_i;
                    pass_d   = '0;
                    slot_d   = '0;
                    state_d  = cfg_bad ? RS_FINISH : RS_INIT;
                end
            end
            RS_INIT: begin
                if (red_is_init_i) begin
                    state_d = RS_COLLECT;
                end
            end
            RS_COLLECT: begin
                if (red_hs) begin
                    if (final_pass) begin
                        out_d       = red_i;
                        out_valid_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    if (last_slot && final_pass) begin
                        state_d = RS_FINISH;
                    end else begin
                        state_d = RS_INIT;
                        if (last_slot) begin
                            slot_d = '0;
                            pass_d = pass_q + CntW'(1);
                        end else begin
                            slot_d = slot_q + CntW'(1);
                        end
                    end
                end
            end
            RS_FINISH: begin
                // The last beat leaves on this edge or already has.
                if (!out_valid_q || out_ready_i) begin
                    done_d  = 1'b1;
                    state_d = RS_IDLE;
                end
            end
            default: state_d = RS_IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        red_enable_o = 1'b0;
        red_load_o   = 1'b0;
        init_valid_o = 1'b0;
        init_o       = '0;
        red_ready_o  = 1'b0;
        busy_o       = (state_q != RS_IDLE);

        case (state_q)
            RS_INIT: begin
                red_enable_o = 1'b1;
                if (pass_q != '0) begin
                    red_load_o   = 1'b1;
                    init_o       = mem_rdata;
                    init_valid_o = ~red_is_init_i;
                end
            end
            RS_COLLECT: begin
                red_enable_o = 1'b1;
                red_ready_o  = final_pass ? (~out_valid_q | out_ready_i) : 1'b1;
            end
            default: ;
        endcase
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_redmule_reduction_sink.sv
module tb_redmule_reduction_sink;

    localparam int W  = 4;
    localparam int B  = 16;
    localparam int DW = W * B;
    localparam int D  = 8;
    localparam int CW = 16;

    localparam logic [63:0] V3C = 64'h3C00_3C00_3C00_3C00;
    localparam logic [63:0] V40 = 64'h4000_4000_4000_4000;
    localparam logic [63:0] VA  = 64'h4200_4200_4200_4200;
    localparam logic [63:0] VB  = 64'h4400_4400_4400_4400;
    localparam logic [63:0] VC  = 64'h4600_4600_4600_4600;
    localparam logic [63:0] VD  = 64'h4800_4800_4800_4800;
    localparam logic [63:0] VE  = 64'h4A00_4A00_4A00_4A00;
    localparam logic [63:0] VF  = 64'h4C00_4C00_4C00_4C00;
    localparam logic [63:0] VX  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] VY  = 64'h0F0F_1E1E_2D2D_3C3C;

    logic          clk = 1'b0;
    logic          rst, clear, start;
    logic [CW-1:0] slots, passes;
    logic          red_enable, red_load, init_valid, red_is_init;
    logic [DW-1:0] init_v, red_v, out_v;
    logic          red_valid, red_ready, out_valid, out_ready, busy, done;

    always #5 clk = ~clk;

    redmule_reduction_sink #(
        .Width (W),
        .BITW  (B),
        .Depth (D),
        .CntW  (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .start_i       (start),
        .num_slots_i   (slots),
        .num_passes_i  (passes),
        .red_enable_o  (red_enable),
        .red_load_o    (red_load),
        .init_o        (init_v),
        .init_valid_o  (init_valid),
        .red_is_init_i (red_is_init),
        .red_i         (red_v),
        .red_valid_i   (red_valid),
        .red_ready_o   (red_ready),
        .out_o         (out_v),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .busy_o        (busy),
        .done_o        (done)
    );

    // flags = {busy, done, enable, load, init_valid, red_ready, out_valid}
    typedef struct {
        logic          start;
        logic [CW-1:0] slots;
        logic [CW-1:0] passes;
        logic          is_init;
        logic          rvalid;
        logic [63:0]   rdata;
        logic          oready;
        logic [6:0]    flags;
        logic [63:0]   init;
        logic [63:0]   out;
    } vec_t;

    vec_t vecs [23];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic st, input int sl, input int pa,
                                input logic ii, input logic rv, input logic [63:0] rd,
                                input logic ordy, input logic [6:0] fl,
                                input logic [63:0] ini, input logic [63:0] ou);
        vec_t v;
        v.start = st; v.slots = CW'(sl); v.passes = CW'(pa);
        v.is_init = ii; v.rvalid = rv; v.rdata = rd; v.oready = ordy;
        v.flags = fl; v.init = ini; v.out = ou;
        return v;
    endfunction

    function automatic logic [6:0] flags_now();
        return {busy, done, red_enable, red_load, init_valid, red_ready, out_valid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        start = 1'b0; clear = 1'b0; slots = '0; passes = '0;
        red_is_init = 1'b0; red_valid = 1'b0; red_v = '0; out_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int sl, input int pa);
        drive_idle();
        start = 1'b1; slots = CW'(sl); passes = CW'(pa);
        step();
        drive_idle();
    endtask

    task automatic run_rows(input int lo, input int hi, input bit perturb, input string tag);
        for (int i = lo; i <= hi; i++) begin
            drive_idle();
            start       = vecs[i].start;
            slots       = vecs[i].slots;
            passes      = vecs[i].passes;
            red_is_init = vecs[i].is_init;
            red_valid   = vecs[i].rvalid;
            red_v       = vecs[i].rdata;
            out_ready   = vecs[i].oready;
            if (perturb && vecs[i].flags[6]) begin
                start = 1'b1; slots = CW'(3); passes = CW'(3);
            end
            #1;
            chk($sformatf("%s row%0d flags", tag, i), 64'(flags_now()), 64'(vecs[i].flags));
            chk($sformatf("%s row%0d init", tag, i), init_v, vecs[i].init);
            chk($sformatf("%s row%0d out", tag, i), out_v, vecs[i].out);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // single pass, 2 slots
        vecs[0]  = mk(1, 2, 1, 0, 0, 0,   0, 7'b0000000, 0,  0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,   0, 7'b1010000, 0,  0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0,   0, 7'b1010000, 0,  0);
        vecs[3]  = mk(0, 0, 0, 0, 1, V3C, 1, 7'b1010010, 0,  0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0,   1, 7'b1010001, 0,  V3C);
        vecs[5]  = mk(0, 0, 0, 0, 1, V40, 0, 7'b1010010, 0,  V3C);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0,   1, 7'b1000001, 0,  V40);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,   0, 7'b0100000, 0,  V40);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0,   0, 7'b0000000, 0,  V40);
        // two passes, 2 slots
        vecs[9]  = mk(1, 2, 2, 0, 0, 0,   0, 7'b0000000, 0,  V40);
        vecs[10] = mk(0, 0, 0, 1, 0, 0,   0, 7'b1010000, 0,  V40);
        vecs[11] = mk(0, 0, 0, 0, 1, VA,  1, 7'b1010010, 0,  V40);
        vecs[12] = mk(0, 0, 0, 1, 0, 0,   0, 7'b1010000, 0,  V40);
        vecs[13] = mk(0, 0, 0, 0, 1, VB,  0, 7'b1010010, 0,  V40);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,   0, 7'b1011100, VA, V40);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,   0, 7'b1011100, VA, V40);
        vecs[16] = mk(0, 0, 0, 1, 0, 0,   0, 7'b1011000, VA, V40);
        vecs[17] = mk(0, 0, 0, 0, 1, VC,  1, 7'b1010010, 0,  V40);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,   1, 7'b1011101, VB, VC);
        vecs[19] = mk(0, 0, 0, 1, 0, 0,   1, 7'b1011000, VB, VC);
        vecs[20] = mk(0, 0, 0, 0, 1, VD,  1, 7'b1010010, 0,  VC);
        vecs[21] = mk(0, 0, 0, 0, 0, 0,   1, 7'b1000001, 0,  VD);
        vecs[22] = mk(0, 0, 0, 0, 0, 0,   0, 7'b0100000, 0,  VD);

        drive_idle();
        rst = 1'b1;
        step();
        step();
        chk("reset flags", 64'(flags_now()), 64'd0);
        chk("reset out", out_v, 64'd0);
        chk("reset init", init_v, 64'd0);
        rst = 1'b0;

        run_rows(0, 22, 1'b0, "table");

        // backpressure on the final pass
        kick(2, 1);
        red_is_init = 1'b1;
        step();
        drive_idle();
        red_valid = 1'b1; red_v = VE; out_ready = 1'b1;
        #1 chk("bp first ready", 64'(red_ready), 64'd1);
        step();
        drive_idle();
        red_is_init = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            drive_idle();
            red_valid = 1'b1; red_v = VF; out_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d flags", k), 64'(flags_now()), 64'(7'b1010001));
            chk($sformatf("bp%0d out", k), out_v, VE);
            step();
        end
        red_valid = 1'b1; red_v = VF; out_ready = 1'b1;
        #1 chk("bp release ready", 64'(red_ready), 64'd1);
        step();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("bp finish%0d flags", k), 64'(flags_now()), 64'(7'b1000001));
            chk($sformatf("bp finish%0d out", k), out_v, VF);
            step();
        end
        out_ready = 1'b1;
        step();
        drive_idle();
        #1 chk("bp done", 64'(flags_now()), 64'(7'b0100000));
        step();
        chk("bp idle", 64'(flags_now()), 64'd0);

        // zero and illegal configurations finish without transfers
        for (int c = 0; c < 3; c++) begin
            int sl, pa;
            sl = (c == 0) ? 0 : (c == 1) ? 9 : 4;
            pa = (c == 2) ? 0 : 3;
            kick(sl, pa);
            #1 chk($sformatf("cfg%0d busy", c), 64'(flags_now()), 64'(7'b1000000));
            step();
            chk($sformatf("cfg%0d done", c), 64'(flags_now()), 64'(7'b0100000));
            step();
            chk($sformatf("cfg%0d idle", c), 64'(flags_now()), 64'd0);
        end

        // Depth slots is legal; abort it from INIT with clear
        kick(D, 1);
        chk("depth legal", 64'(flags_now()), 64'(7'b1010000));
        clear = 1'b1;
        step();
        drive_idle();
        chk("clear in init", 64'(flags_now()), 64'd0);

        // clear during the final-pass COLLECT
        kick(1, 2);
        red_is_init = 1'b1;
        step();
        drive_idle();
        red_valid = 1'b1; red_v = VX;
        step();
        drive_idle();
        #1;
        chk("clr replay flags", 64'(flags_now()), 64'(7'b1011100));
        chk("clr replay init", init_v, VX);
        red_is_init = 1'b1;
        step();
        drive_idle();
        clear = 1'b1; red_valid = 1'b1; red_v = VY;
        #1 chk("clr collect flags", 64'(flags_now()), 64'(7'b1010010));
        step();
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("clr idle%0d flags", k), 64'(flags_now()), 64'd0);
            chk($sformatf("clr idle%0d out", k), out_v, 64'd0);
            step();
        end
        kick(1, 1);
        red_is_init = 1'b1;
        step();
        drive_idle();
        red_valid = 1'b1; red_v = VY; out_ready = 1'b1;
        step();
        drive_idle();
        out_ready = 1'b1;
        #1;
        chk("fresh flags", 64'(flags_now()), 64'(7'b1000001));
        chk("fresh out", out_v, VY);
        step();
        drive_idle();
        chk("fresh done", 64'(flags_now()), 64'(7'b0100000));

        // start pulses during a job must not disturb it
        clear = 1'b1;
        step();
        drive_idle();
        run_rows(0, 8, 1'b1, "perturb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
